// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants: fetch FSM states, reset vector, instruction field slices.
// Imported by the fetch stage and its next-PC helper.
package mips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam int OP_MSB      = 31;
  localparam int OP_LSB      = 26;
  localparam int FUNCT_MSB   = 5;
  localparam int FUNCT_LSB   = 0;
  localparam int JTARGET_MSB = 25;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: the fetch unit holds req/addr until the memory answers with ready/rdata.
// The memory side may stall for any number of cycles; ready completes the request.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC select: jump over taken branch (beq/bne) over sequential pc + 4.
// Zero latency; purely combinational, no flow control.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] signimm,
  input  logic        pcsrc,
  input  logic        bneflag,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pcplus4,
  output logic [31:0] next_pc
);

  logic take_br;
  logic unused_op;

  // The opcode field has no part in target formation.
  assign unused_op = &{1'b0, instr[OP_MSB:OP_LSB]};

  assign pcplus4 = pc + 32'd4;
  assign take_br = pcsrc | (bneflag & ~zero);

  always_comb begin
    next_pc = pcplus4;
    if (jump) begin
      next_pc = {pcplus4[31:28], instr[JTARGET_MSB:0], 2'b00};
    end else if (take_br) begin
      next_pc = pcplus4 + (signimm << 2);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC-sequencing stage: one request per instruction, instr held stable through EXEC until retire.
// Min 2 cycles/instr; waits indefinitely on imem_ready, holds in EXEC while stall is high.
module fetch_unit
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  fetch_unit_if.master       imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pcplus4,
  input  logic               pcsrc,
  input  logic               bneflag,
  input  logic               zero,
  input  logic               jump,
  input  logic [31:0]        signimm,
  input  logic               stall,
  output logic [31:0]        retired
);

  fetch_state_t state;
  logic         req_q;
  logic         valid_q;
  logic [31:0]  next_pc;

  pc_next u_pc_next (
    .pc      (pc),
    .instr   (instr),
    .signimm (signimm),
    .pcsrc   (pcsrc),
    .bneflag (bneflag),
    .zero    (zero),
    .jump    (jump),
    .pcplus4 (pcplus4),
    .next_pc (next_pc)
  );

  assign imem.req    = req_q;
  assign imem.addr   = pc;
  assign instr_valid = valid_q;

  // req/valid are registered alongside the state so they always mirror it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem.ready) begin
            instr   <= imem.rdata;
            state   <= EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc      <= next_pc;
            retired <= retired + 32'd1;
            state   <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= FETCH;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized instructions against a transaction-level PC model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        pcsrc;
  logic        bneflag;
  logic        zero;
  logic        jump;
  logic [31:0] signimm;
  logic        stall;
  logic [31:0] retired;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .pcsrc       (pcsrc),
    .bneflag     (bneflag),
    .zero        (zero),
    .jump        (jump),
    .signimm     (signimm),
    .stall       (stall),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Outputs are sampled and inputs changed at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic [31:0] simm, input logic br_eq,
                                           input logic br_ne, input logic z, input logic j);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (j) return {seq[31:28], ins[25:0], 2'b00};
    if (br_eq || (br_ne && !z)) return seq + simm * 32'd4;
    return seq;
  endfunction

  task automatic rand_ctl();
    pcsrc   = 1'($urandom);
    bneflag = 1'($urandom);
    zero    = 1'($urandom);
    jump    = 1'($urandom);
    signimm = $urandom;
  endtask

  // One full instruction: fetch with latency lat, nstall stalled EXEC cycles, then retire with given controls.
  task automatic do_instr(input logic [31:0] data, input int lat, input int nstall,
                          input logic c_pcsrc, input logic c_bne, input logic c_zero,
                          input logic c_jump, input logic [31:0] c_simm);
    for (int i = 0; i <= lat; i++) begin
      chk("fetch_req", 32'(imem.req), 32'd1);
      chk("fetch_addr", imem.addr, m_pc);
      chk("fetch_vld", 32'(instr_valid), 32'd0);
      rand_ctl();
      imem.ready = (i == lat);
      imem.rdata = (i == lat) ? data : $urandom;
      step();
    end
    for (int s = 0; s <= nstall; s++) begin
      chk("exec_vld", 32'(instr_valid), 32'd1);
      chk("exec_req", 32'(imem.req), 32'd0);
      chk("exec_instr", instr, data);
      chk("exec_pc", pc, m_pc);
      chk("exec_pcplus4", pcplus4, m_pc + 32'd4);
      chk("exec_retired", retired, m_ret);
      if (s < nstall) begin
        stall = 1'b1;
        rand_ctl();
        imem.ready = 1'($urandom);
        imem.rdata = $urandom;
      end else begin
        stall      = 1'b0;
        imem.ready = 1'b0;
        pcsrc      = c_pcsrc;
        bneflag    = c_bne;
        zero       = c_zero;
        jump       = c_jump;
        signimm    = c_simm;
      end
      step();
    end
    stall      = 1'b0;
    imem.ready = 1'b0;
    m_pc  = ref_next(m_pc, data, c_simm, c_pcsrc, c_bne, c_zero, c_jump);
    m_ret = m_ret + 32'd1;
    chk("retire_pc", pc, m_pc);
    chk("retire_cnt", retired, m_ret);
  endtask

  // Reach an arbitrary aligned target with a taken beq.
  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] diff;
    diff = target - m_pc - 32'd4;
    do_instr(32'h1000_0000, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, diff >> 2);
  endtask

  task automatic jump_to(input logic [31:0] target);
    logic [31:0] ins;
    ins = {6'b000010, target[27:2]};
    do_instr(ins, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; imem.ready = 1'b0; imem.rdata = '0;
    pcsrc = 1'b0; bneflag = 1'b0; zero = 1'b0; jump = 1'b0; signimm = '0;
    @(negedge clk);
    step();
    chk("rst_req", 32'(imem.req), 32'd1);
    chk("rst_addr", imem.addr, 32'h0);
    chk("rst_vld", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_pcplus4", pcplus4, 32'h4);
    reset = 1'b0;
    m_pc = 32'h0; m_ret = 32'h0;

    do_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("first_pc", pc, 32'h4);
    chk("first_retired", retired, 32'h1);

    jump_to(32'h40);
    chk("jump_40", pc, 32'h40);
    do_instr(32'h1234_5678, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    jump_to(32'h10);
    do_instr(32'h1000_0003, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
    chk("beq_taken", pc, 32'h20);
    jump_to(32'h10);
    do_instr(32'h1400_0003, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3);
    chk("bne_taken", pc, 32'h20);
    jump_to(32'h10);
    do_instr(32'h1400_0003, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd3);
    chk("bne_not_taken", pc, 32'h14);
    jump_to(32'h10);
    do_instr(32'h1000_ffff, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    chk("beq_back", pc, 32'h10);

    goto_pc(32'h1000_0000);
    chk("goto_hi", pc, 32'h1000_0000);
    do_instr(32'h0800_0040, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd3);
    chk("jump_prio", pc, 32'h1000_0100);

    do_instr(32'hAC22_0008, 2, 5, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    goto_pc(32'h80);
    chk("goto_80", pc, 32'h80);
    for (int i = 0; i < 3; i++) begin
      chk("rstf_addr", imem.addr, 32'h80);
      step();
    end
    reset = 1'b1; imem.ready = 1'b1; imem.rdata = 32'hDEAD_BEEF;
    step();
    reset = 1'b0; imem.ready = 1'b0;
    m_pc = 32'h0; m_ret = 32'h0;
    chk("rstf_addr0", imem.addr, 32'h0);
    chk("rstf_req", 32'(imem.req), 32'd1);
    chk("rstf_retired", retired, 32'h0);
    chk("rstf_vld", 32'(instr_valid), 32'd0);
    chk("rstf_instr", instr, 32'h0);

    do_instr(32'h2009_0001, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    imem.ready = 1'b1; imem.rdata = 32'h0123_4567;
    step();
    imem.ready = 1'b0;
    chk("rste_vld", 32'(instr_valid), 32'd1);
    stall = 1'b1; reset = 1'b1;
    step();
    stall = 1'b0; reset = 1'b0;
    m_pc = 32'h0; m_ret = 32'h0;
    chk("rste_retired", retired, 32'h0);
    chk("rste_pc", pc, 32'h0);
    chk("rste_vld0", 32'(instr_valid), 32'd0);

    for (int n = 0; n < 40; n++) begin
      do_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
               ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
